// File: rtl/wind_sample_sequencer_if.sv
// Result handshake between the wind sequencer and the SPI/display side.
// The sequencer is the master. It drives speed and speed_valid.
// The consumer is the slave. It returns speed_ack.
interface wind_sample_sequencer_if;
    logic [7:0] speed;
    logic       speed_valid;
    logic       speed_ack;

    modport master (output speed, output speed_valid, input speed_ack);
    modport slave  (input speed, input speed_valid, output speed_ack);
endinterface

// File: rtl/wind_sample_sequencer.sv
// Wind-speed sequencer running on the 1 ms tick.
// It debounces the anemometer contact and counts rotations over a fixed window.
// It then multiplies the count serially and publishes the speed with a too-windy flag.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_COUNT   | counting rotations; window end captures the count
// ST_MUL     | 8-cycle LSB-first shift-add of snapshot x ONE_ROTATION_SPEED
// ST_PUBLISH | one cycle: latch saturated speed, raise valid, update flag
module wind_sample_sequencer #(
    parameter int WINDOW_MS          = 2000,
    parameter int ONE_ROTATION_SPEED = 1563,
    parameter int DEBOUNCE_MS        = 2,
    parameter int WIND_HI            = 3,
    parameter int WIND_LO            = 2
) (
    input  logic                            ms_clk,
    input  logic                            reset,
    input  logic                            i_windsensor,
    input  logic                            i_enable,
    wind_sample_sequencer_if.master         sif,
    output logic                            o_overrun,
    output logic                            o_too_windy,
    output logic                            o_busy,
    output logic [7:0]                      o_rot_count
);
    localparam int                WIN_W    = $clog2(WINDOW_MS);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW_MS - 1);
    localparam logic [3:0]        DEB_LAST = 4'(DEBOUNCE_MS - 1);
    localparam logic [19:0]       MCAND    = 20'(ONE_ROTATION_SPEED);
    localparam logic [7:0]        HI_TH    = 8'(WIND_HI);
    localparam logic [7:0]        LO_TH    = 8'(WIND_LO);

    typedef enum logic [1:0] {
        ST_COUNT   = 2'd0,
        ST_MUL     = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_deb;
    logic [3:0]        r_stab;
    logic [WIN_W-1:0]  r_win_cnt;
    logic [7:0]        r_rot_count;
    logic [7:0]        r_snap;
    logic [19:0]       r_mcand;
    logic [19:0]       r_acc;
    logic [2:0]        r_bit;
    logic [7:0]        r_speed;
    logic              r_speed_valid;
    logic              r_overrun;
    logic              r_too_windy;
    logic              r_busy;

    logic              w_disagree;
    logic              w_deb_flip;
    logic              w_rot;
    logic              w_win_end;
    logic [9:0]        w_quot;
    logic [7:0]        w_new_speed;

    assign w_disagree  = (r_sync2 != r_deb);
    assign w_deb_flip  = w_disagree && (r_stab == DEB_LAST);
    // A rotation is counted on the same edge where the debounced level rises.
    assign w_rot       = w_deb_flip && r_sync2;
    assign w_win_end   = i_enable && (r_win_cnt == WIN_LAST);
    assign w_quot      = r_acc[19:10];
    assign w_new_speed = (w_quot > 10'd255) ? 8'hFF : w_quot[7:0];

    assign sif.speed       = r_speed;
    assign sif.speed_valid = r_speed_valid;
    assign o_overrun       = r_overrun;
    assign o_too_windy     = r_too_windy;
    assign o_busy          = r_busy;
    assign o_rot_count     = r_rot_count;

    // Synchronise the raw contact, then debounce it. Any agreement restarts the stability count.
    always_ff @(posedge ms_clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_stab  <= 4'd0;
        end else begin
            r_sync1 <= i_windsensor;
            r_sync2 <= r_sync1;
            if (w_disagree) begin
                if (w_deb_flip) begin
                    r_deb  <= r_sync2;
                    r_stab <= 4'd0;
                end else begin
                    r_stab <= r_stab + 4'd1;
                end
            end else begin
                r_stab <= 4'd0;
            end
        end
    end

    // The window timer and the rotation counter run in every state, so no rotation is lost during MUL.
    always_ff @(posedge ms_clk or negedge reset) begin
        if (!reset) begin
            r_win_cnt   <= '0;
            r_rot_count <= 8'd0;
        end else if (!i_enable) begin
            r_win_cnt   <= '0;
            r_rot_count <= 8'd0;
        end else if (w_win_end) begin
            r_win_cnt   <= '0;
            r_rot_count <= w_rot ? 8'd1 : 8'd0;
        end else begin
            r_win_cnt <= r_win_cnt + WIN_W'(1);
            if (w_rot && (r_rot_count != 8'hFF)) begin
                r_rot_count <= r_rot_count + 8'd1;
            end
        end
    end

    // Sequencer FSM with the serial multiplier and the result handshake.
    always_ff @(posedge ms_clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_COUNT;
            r_snap        <= 8'd0;
            r_mcand       <= 20'd0;
            r_acc         <= 20'd0;
            r_bit         <= 3'd0;
            r_speed       <= 8'd0;
            r_speed_valid <= 1'b0;
            r_overrun     <= 1'b0;
            r_too_windy   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            if (sif.speed_ack) begin
                r_speed_valid <= 1'b0;
            end
            case (r_state)
                ST_COUNT: begin
                    if (w_win_end) begin
                        r_snap  <= r_rot_count;
                        r_mcand <= MCAND;
                        r_acc   <= 20'd0;
                        r_bit   <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (r_snap[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_snap  <= r_snap >> 1;
                    r_mcand <= r_mcand << 1;
                    r_bit   <= r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        r_state <= ST_PUBLISH;
                    end
                end
                ST_PUBLISH: begin
                    r_speed       <= w_new_speed;
                    r_speed_valid <= 1'b1;
                    // Overwriting a result that was never acknowledged is recorded. A same-edge ack is not an overrun.
                    if (r_speed_valid && !sif.speed_ack) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_new_speed > HI_TH) begin
                        r_too_windy <= 1'b1;
                    end else if (w_new_speed < LO_TH) begin
                        r_too_windy <= 1'b0;
                    end
                    r_busy  <= 1'b0;
                    r_state <= ST_COUNT;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_COUNT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wind_sample_sequencer.sv
// Scenario bench for wind_sample_sequencer.
// Expected speeds and flags are pushed into a queue when a window's stimulus is driven.
// They are popped on the publish edge, which is the 10th edge after the edge where win_cnt reaches W-1.
module tb_wind_sample_sequencer;
    localparam int W = 2000;

    logic       ms_clk = 1'b0;
    logic       reset;
    logic       ws;
    logic       en;
    logic       overrun;
    logic       too_windy;
    logic       busy;
    logic [7:0] rot_count;

    wind_sample_sequencer_if sif();

    wind_sample_sequencer #(
        .WINDOW_MS(W), .ONE_ROTATION_SPEED(1563), .DEBOUNCE_MS(2), .WIND_HI(3), .WIND_LO(2)
    ) dut (
        .ms_clk(ms_clk),
        .reset(reset),
        .i_windsensor(ws),
        .i_enable(en),
        .sif(sif),
        .o_overrun(overrun),
        .o_too_windy(too_windy),
        .o_busy(busy),
        .o_rot_count(rot_count)
    );

    always #5 ms_clk = ~ms_clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] q_speed[$];
    logic       q_tw[$];
    logic       tw_model  = 1'b0;
    logic       sv_model  = 1'b0;
    logic       ovr_model = 1'b0;

    function automatic int spd_of(input int c);
        int p;
        p = (c * 1563) >> 10;
        return (p > 255) ? 255 : p;
    endfunction

    task automatic tick;
        @(posedge ms_clk);
        #1;
    endtask

    task automatic push_expected(input int cnt);
        int s;
        s = spd_of(cnt);
        if (s > 3) tw_model = 1'b1;
        else if (s < 2) tw_model = 1'b0;
        q_speed.push_back(8'(s));
        q_tw.push_back(tw_model);
    endtask

    // One enabled window. The stimulus is driven first, and publish timing is checked to the exact edge.
    task automatic run_window(input int nrot, input int hi, input int lo, input bit bounce,
                              input bit ack_at_pub, input bit ack_after, input string name);
        int e;
        int cnt;
        logic [7:0] es;
        logic et;
        e = 0;
        en = 1'b1;
        if (bounce) begin
            for (int i = 0; i < 6; i++) begin
                ws = 1'b1; tick(); e++;
                ws = 1'b0; tick(); e++;
            end
            ws = 1'b1;
            repeat (20) begin tick(); e++; end
            ws = 1'b0;
            repeat (10) begin tick(); e++; end
            cnt = 1;
        end else begin
            for (int i = 0; i < nrot; i++) begin
                ws = 1'b1;
                repeat (hi) begin tick(); e++; end
                ws = 1'b0;
                repeat (lo) begin tick(); e++; end
            end
            cnt = (nrot > 255) ? 255 : nrot;
        end
        checks++;
        if (rot_count !== 8'(cnt))
            $display("FAIL %s rot_count: got %0d expected %0d", name, rot_count, cnt);
        if (rot_count !== 8'(cnt)) errors++;
        push_expected(cnt);
        while (e < W + 8) begin tick(); e++; end
        checks++;
        if (busy !== 1'b1 || sif.speed_valid !== sv_model) begin
            errors++;
            $display("FAIL %s pre_publish: busy=%0b valid=%0b expected busy=1 valid=%0b",
                     name, busy, sif.speed_valid, sv_model);
        end
        if (ack_at_pub) sif.speed_ack = 1'b1;
        tick(); e++;
        sif.speed_ack = 1'b0;
        if (q_speed.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", name);
            es = 8'd0;
            et = 1'b0;
        end else begin
            es = q_speed.pop_front();
            et = q_tw.pop_front();
        end
        ovr_model = ovr_model | (sv_model & ~ack_at_pub);
        sv_model  = 1'b1;
        checks++;
        if (sif.speed !== es) begin
            errors++;
            $display("FAIL %s speed: got %0d expected %0d", name, sif.speed, es);
        end
        checks++;
        if (too_windy !== et) begin
            errors++;
            $display("FAIL %s too_windy: got %0b expected %0b", name, too_windy, et);
        end
        checks++;
        if (sif.speed_valid !== 1'b1 || busy !== 1'b0 || rot_count !== 8'd0) begin
            errors++;
            $display("FAIL %s post_publish: valid=%0b busy=%0b rot=%0d expected 1 0 0",
                     name, sif.speed_valid, busy, rot_count);
        end
        checks++;
        if (overrun !== ovr_model) begin
            errors++;
            $display("FAIL %s overrun: got %0b expected %0b", name, overrun, ovr_model);
        end
        en = 1'b0;
        tick();
        if (ack_after) begin
            sif.speed_ack = 1'b1;
            tick();
            sif.speed_ack = 1'b0;
            sv_model = 1'b0;
            checks++;
            if (sif.speed_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s ack: valid got %0b expected 0", name, sif.speed_valid);
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if (sif.speed !== 8'd0 || sif.speed_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: speed=%0d valid=%0b overrun=%0b expected 0 0 0",
                     sif.speed, sif.speed_valid, overrun);
        end
        checks++;
        if (too_windy !== 1'b0 || busy !== 1'b0 || rot_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_status: tw=%0b busy=%0b rot=%0d expected 0 0 0",
                     too_windy, busy, rot_count);
        end
    endtask

    task automatic test_basic;
        run_window(5, 10, 10, 1'b0, 1'b0, 1'b1, "basic");
        sif.speed_ack = 1'b1;
        tick();
        sif.speed_ack = 1'b0;
        checks++;
        if (sif.speed_valid !== 1'b0 || sif.speed !== 8'd7) begin
            errors++;
            $display("FAIL idle_ack: valid=%0b speed=%0d expected 0 7", sif.speed_valid, sif.speed);
        end
    endtask

    task automatic test_debounce;
        run_window(1, 0, 0, 1'b1, 1'b0, 1'b1, "debounce");
    endtask

    task automatic test_saturation;
        run_window(300, 3, 3, 1'b0, 1'b0, 1'b1, "saturation");
    endtask

    task automatic test_overrun;
        run_window(3, 10, 10, 1'b0, 1'b0, 1'b0, "overrun_first");
        run_window(2, 10, 10, 1'b0, 1'b0, 1'b0, "overrun_second");
        run_window(1, 10, 10, 1'b0, 1'b1, 1'b1, "overrun_ack_at_pub");
    endtask

    task automatic test_hysteresis;
        int counts[5] = '{2, 3, 2, 1, 0};
        foreach (counts[i]) run_window(counts[i], 10, 10, 1'b0, 1'b0, 1'b1, "hysteresis");
    endtask

    task automatic test_boundary;
        int e;
        logic [7:0] es;
        logic et;
        e = 0;
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ws = 1'b1; repeat (10) begin tick(); e++; end
            ws = 1'b0; repeat (10) begin tick(); e++; end
        end
        push_expected(2);
        while (e < W - 4) begin tick(); e++; end
        ws = 1'b1;
        while (e < W) begin tick(); e++; end
        checks++;
        if (rot_count !== 8'd1) begin
            errors++;
            $display("FAIL boundary_edge_rot: got %0d expected 1", rot_count);
        end
        ws = 1'b0;
        while (e < W + 3) begin tick(); e++; end
        ws = 1'b1;
        while (e < W + 9) begin tick(); e++; end
        es = q_speed.pop_front();
        et = q_tw.pop_front();
        ovr_model = ovr_model | sv_model;
        sv_model  = 1'b1;
        checks++;
        if (sif.speed !== es || too_windy !== et || sif.speed_valid !== 1'b1) begin
            errors++;
            $display("FAIL boundary_publish: speed=%0d tw=%0b valid=%0b expected %0d %0b 1",
                     sif.speed, too_windy, sif.speed_valid, es, et);
        end
        checks++;
        if (rot_count !== 8'd2) begin
            errors++;
            $display("FAIL boundary_mul_rot: got %0d expected 2", rot_count);
        end
        while (e < W + 12) begin tick(); e++; end
        ws = 1'b0;
        while (e < W + 100) begin tick(); e++; end
        ws = 1'b1; repeat (10) begin tick(); e++; end
        ws = 1'b0; repeat (10) begin tick(); e++; end
        push_expected(3);
        while (e < 2 * W + 9) begin tick(); e++; end
        es = q_speed.pop_front();
        et = q_tw.pop_front();
        ovr_model = ovr_model | sv_model;
        checks++;
        if (sif.speed !== es || too_windy !== et || overrun !== ovr_model) begin
            errors++;
            $display("FAIL boundary_next_window: speed=%0d tw=%0b ovr=%0b expected %0d %0b %0b",
                     sif.speed, too_windy, overrun, es, et, ovr_model);
        end
        en = 1'b0;
        tick();
        sif.speed_ack = 1'b1;
        tick();
        sif.speed_ack = 1'b0;
        sv_model = 1'b0;
    endtask

    task automatic test_enable_mid;
        int e;
        bit seen;
        e = 0;
        seen = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ws = 1'b1; repeat (10) begin tick(); e++; end
            ws = 1'b0; repeat (10) begin tick(); e++; end
        end
        while (e < 1000) begin tick(); e++; end
        checks++;
        if (rot_count !== 8'd3) begin
            errors++;
            $display("FAIL enable_mid_count: got %0d expected 3", rot_count);
        end
        en = 1'b0;
        while (e < W + 20) begin tick(); e++; if (busy) seen = 1'b1; end
        checks++;
        if (seen || sif.speed_valid !== 1'b0 || rot_count !== 8'd0) begin
            errors++;
            $display("FAIL enable_mid_nopublish: busy_seen=%0b valid=%0b rot=%0d expected 0 0 0",
                     seen, sif.speed_valid, rot_count);
        end
    endtask

    task automatic test_enable_mul;
        int e;
        bit seen;
        logic [7:0] es;
        logic et;
        e = 0;
        seen = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ws = 1'b1; repeat (10) begin tick(); e++; end
            ws = 1'b0; repeat (10) begin tick(); e++; end
        end
        push_expected(3);
        while (e < W + 3) begin tick(); e++; end
        en = 1'b0;
        while (e < W + 9) begin tick(); e++; end
        es = q_speed.pop_front();
        et = q_tw.pop_front();
        sv_model = 1'b1;
        checks++;
        if (sif.speed !== es || too_windy !== et || sif.speed_valid !== 1'b1) begin
            errors++;
            $display("FAIL enable_mul_publish: speed=%0d tw=%0b valid=%0b expected %0d %0b 1",
                     sif.speed, too_windy, sif.speed_valid, es, et);
        end
        while (e < 2 * W + 30) begin tick(); e++; if (busy) seen = 1'b1; end
        checks++;
        if (seen || rot_count !== 8'd0) begin
            errors++;
            $display("FAIL enable_mul_hold: busy_seen=%0b rot=%0d expected 0 0", seen, rot_count);
        end
        sif.speed_ack = 1'b1;
        tick();
        sif.speed_ack = 1'b0;
        sv_model = 1'b0;
    endtask

    task automatic test_reset_mid_mul;
        int e;
        bit seen;
        e = 0;
        seen = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ws = 1'b1; repeat (10) begin tick(); e++; end
            ws = 1'b0; repeat (10) begin tick(); e++; end
        end
        while (e < W + 4) begin tick(); e++; end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_mul_busy: got %0b expected 1", busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (sif.speed !== 8'd0 || sif.speed_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0
            || too_windy !== 1'b0 || rot_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_mul_clear: speed=%0d valid=%0b busy=%0b ovr=%0b tw=%0b rot=%0d expected all 0",
                     sif.speed, sif.speed_valid, busy, overrun, too_windy, rot_count);
        end
        reset = 1'b1;
        tw_model = 1'b0; sv_model = 1'b0; ovr_model = 1'b0;
        while (e < W + 20) begin tick(); e++; if (busy || sif.speed_valid) seen = 1'b1; end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_mul_nopublish: activity seen=%0b expected 0", seen);
        end
        en = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        ws = 1'b0;
        en = 1'b0;
        sif.speed_ack = 1'b0;
        #22;
        test_reset();
        @(posedge ms_clk);
        #1;
        reset = 1'b1;
        tick();
        test_basic();
        test_debounce();
        test_saturation();
        test_overrun();
        test_hysteresis();
        test_boundary();
        test_enable_mid();
        test_enable_mul();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
